// File: rtl/dbus_ctrl_if.sv
// Bundle of the core request/response channel and the DMEM/UART slave-side signals.
// The controller uses the master modport; the environment (core + slaves) uses slave.
interface dbus_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_we;
   logic [DATA_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [3:0]            req_mask;
   logic                  req_stall;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic                  dmem_sel;
   logic                  dmem_we;
   logic [DATA_WIDTH-1:0] dmem_addr;
   logic [DATA_WIDTH-1:0] dmem_wdata;
   logic [3:0]            dmem_mask;
   logic [DATA_WIDTH-1:0] dmem_rdata;
   logic                  uart_sel;
   logic                  uart_we;
   logic [3:0]            uart_addr;
   logic [DATA_WIDTH-1:0] uart_wdata;
   logic                  uart_ready;
   logic [DATA_WIDTH-1:0] uart_rdata;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, req_mask,
      input  dmem_rdata, uart_ready, uart_rdata,
      output req_stall, rsp_valid, rsp_rdata, rsp_err,
      output dmem_sel, dmem_we, dmem_addr, dmem_wdata, dmem_mask,
      output uart_sel, uart_we, uart_addr, uart_wdata
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, req_mask,
      output dmem_rdata, uart_ready, uart_rdata,
      input  req_stall, rsp_valid, rsp_rdata, rsp_err,
      input  dmem_sel, dmem_we, dmem_addr, dmem_wdata, dmem_mask,
      input  uart_sel, uart_we, uart_addr, uart_wdata
   );
endinterface

// File: rtl/dbus_ctrl.sv
// Data-bus controller: one load/store at a time, routed to DMEM (fixed 1-cycle) or UART
// (valid/ready with timeout), stalling the core until a one-cycle response is returned.
module dbus_ctrl #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter logic [3:0]  DMEM_REGION = 4'h2,
   parameter logic [3:0]  UART_REGION = 4'h8,
   parameter int unsigned TIMEOUT     = 255
) (
   input logic         clk,
   input logic         rst,
   dbus_ctrl_if.master bus
);

   typedef enum logic [1:0] {StIdle, StDmemAcc, StUartAcc, StResp} state_e;

   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

   state_e                state_q, state_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            mask_q, mask_d;
   logic                  err_q, err_d;
   logic                  is_dmem_q, is_dmem_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         mask_q    <= '0;
         err_q     <= 1'b0;
         is_dmem_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         mask_q    <= mask_d;
         err_q     <= err_d;
         is_dmem_q <= is_dmem_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      mask_d    = mask_q;
      err_d     = err_q;
      is_dmem_d = is_dmem_q;
      rdata_d   = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               we_d      = bus.req_we;
               addr_d    = bus.req_addr;
               wdata_d   = bus.req_wdata;
               mask_d    = bus.req_mask;
               cnt_d     = '0;
               rdata_d   = '0;
               err_d     = 1'b0;
               is_dmem_d = 1'b0;
               if (bus.req_addr[31:28] == DMEM_REGION) begin
                  is_dmem_d = 1'b1;
                  state_d   = StDmemAcc;
               end else if (bus.req_addr[31:28] == UART_REGION) begin
                  state_d = StUartAcc;
               end else begin
                  err_d   = 1'b1;
                  state_d = StResp;
               end
            end
         end
         StDmemAcc: state_d = StResp;
         StUartAcc: begin
            // Ready is checked first so it wins over a coincident timeout.
            if (bus.uart_ready) begin
               rdata_d = we_q ? '0 : bus.uart_rdata;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = StResp;
            end else if (cnt_q == TimeoutLast) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StResp: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.req_stall  = 1'b0;
      bus.rsp_valid  = 1'b0;
      bus.rsp_rdata  = '0;
      bus.rsp_err    = 1'b0;
      bus.dmem_sel   = 1'b0;
      bus.dmem_we    = 1'b0;
      bus.dmem_addr  = '0;
      bus.dmem_wdata = '0;
      bus.dmem_mask  = '0;
      bus.uart_sel   = 1'b0;
      bus.uart_we    = 1'b0;
      bus.uart_addr  = '0;
      bus.uart_wdata = '0;
      // Reset forces every output low combinationally, so uart_sel drops at once.
      if (!rst) begin
         unique case (state_q)
            StIdle: bus.req_stall = bus.req_valid;
            StDmemAcc: begin
               bus.req_stall  = 1'b1;
               bus.dmem_sel   = 1'b1;
               bus.dmem_we    = we_q;
               bus.dmem_addr  = addr_q;
               bus.dmem_wdata = wdata_q;
               bus.dmem_mask  = mask_q;
            end
            StUartAcc: begin
               bus.req_stall  = 1'b1;
               bus.uart_sel   = 1'b1;
               bus.uart_we    = we_q;
               bus.uart_addr  = addr_q[3:0];
               bus.uart_wdata = wdata_q;
            end
            StResp: begin
               bus.rsp_valid = 1'b1;
               bus.rsp_err   = err_q;
               if (!err_q && !we_q) bus.rsp_rdata = is_dmem_q ? bus.dmem_rdata : rdata_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed bench for dbus_ctrl: DMEM/UART/unmapped accesses, timeout, reset and spacing.
module tb_dbus_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total  = 0;

   dbus_ctrl_if #(.DATA_WIDTH(32)) bus ();

   dbus_ctrl #(
      .DATA_WIDTH (32),
      .DMEM_REGION(4'h2),
      .UART_REGION(4'h8),
      .TIMEOUT    (255)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] mask);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_mask  = mask;
   endtask

   task automatic test_reset();
      drive_req(1'b0, 32'h2000_0000, 32'h0, 4'hF);
      step();
      #1;
      total++;
      if (bus.req_stall !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.dmem_sel !== 1'b0)
         $display("FAIL reset_outputs stall=%b rsp=%b dsel=%b want 000",
                  bus.req_stall, bus.rsp_valid, bus.dmem_sel);
      else passed++;
      rst = 1'b0;
      bus.req_valid = 1'b0;
      step();
      #1;
      total++;
      if (bus.req_stall !== 1'b0 || bus.uart_sel !== 1'b0 || bus.rsp_valid !== 1'b0)
         $display("FAIL reset_idle stall=%b usel=%b rsp=%b want 000",
                  bus.req_stall, bus.uart_sel, bus.rsp_valid);
      else passed++;
   endtask

   task automatic test_dmem_store();
      drive_req(1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF);
      #1;
      total++;
      if (bus.req_stall !== 1'b1 || bus.dmem_sel !== 1'b0)
         $display("FAIL dst_t0 stall=%b dsel=%b want 1 0", bus.req_stall, bus.dmem_sel);
      else passed++;
      step();
      #1;
      total++;
      if (bus.dmem_sel !== 1'b1 || bus.dmem_we !== 1'b1 || bus.dmem_addr !== 32'h2000_0010 ||
          bus.dmem_wdata !== 32'hDEAD_BEEF || bus.dmem_mask !== 4'hF ||
          bus.req_stall !== 1'b1 || bus.uart_sel !== 1'b0 || bus.rsp_valid !== 1'b0)
         $display("FAIL dst_t1 sel=%b we=%b a=%h d=%h m=%h stall=%b usel=%b rsp=%b",
                  bus.dmem_sel, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, bus.dmem_mask,
                  bus.req_stall, bus.uart_sel, bus.rsp_valid);
      else passed++;
      step();
      bus.req_valid  = 1'b0;
      bus.dmem_rdata = 32'h1234_5678;
      #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0 ||
          bus.req_stall !== 1'b0 || bus.dmem_sel !== 1'b0)
         $display("FAIL dst_t2 rsp=%b err=%b rd=%h stall=%b dsel=%b want 1 0 0 0 0",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_stall, bus.dmem_sel);
      else passed++;
      step();
      #1;
      total++;
      if (bus.rsp_valid !== 1'b0) $display("FAIL dst_t3 rsp=%b want 0", bus.rsp_valid);
      else passed++;
   endtask

   task automatic test_dmem_load();
      int usel_seen = 0;
      drive_req(1'b0, 32'h2000_0010, 32'h0, 4'h3);
      #1;
      if (bus.uart_sel === 1'b1) usel_seen++;
      step();
      #1;
      if (bus.uart_sel === 1'b1) usel_seen++;
      total++;
      if (bus.dmem_sel !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_mask !== 4'h3)
         $display("FAIL dld_t1 sel=%b we=%b m=%h want 1 0 3",
                  bus.dmem_sel, bus.dmem_we, bus.dmem_mask);
      else passed++;
      step();
      bus.req_valid  = 1'b0;
      bus.dmem_rdata = 32'hDEAD_BEEF;
      #1;
      if (bus.uart_sel === 1'b1) usel_seen++;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'hDEAD_BEEF)
         $display("FAIL dld_t2 rsp=%b err=%b rd=%h want 1 0 deadbeef",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
      else passed++;
      total++;
      if (usel_seen !== 0) $display("FAIL dld_no_uart uart_sel cycles=%0d want 0", usel_seen);
      else passed++;
      step();
   endtask

   task automatic test_uart_load();
      int sel_ok = 0;
      drive_req(1'b0, 32'h8000_0004, 32'h0, 4'hF);
      for (int i = 0; i < 4; i++) begin
         step();
         bus.uart_ready = (i == 3);
         bus.uart_rdata = (i == 3) ? 32'h41 : 32'h99;
         #1;
         if (bus.uart_sel === 1'b1 && bus.uart_addr === 4'h4 && bus.uart_we === 1'b0 &&
             bus.dmem_sel === 1'b0 && bus.req_stall === 1'b1 && bus.rsp_valid === 1'b0)
            sel_ok++;
      end
      total++;
      if (sel_ok !== 4) $display("FAIL uld_sel good_cycles=%0d want 4", sel_ok);
      else passed++;
      step();
      bus.uart_ready = 1'b0;
      bus.uart_rdata = 32'h0;
      bus.req_valid  = 1'b0;
      #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h41 ||
          bus.uart_sel !== 1'b0)
         $display("FAIL uld_rsp rsp=%b err=%b rd=%h usel=%b want 1 0 41 0",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.uart_sel);
      else passed++;
      step();
   endtask

   // ready_at: sel cycle (1-based) on which uart_ready rises; 0 means never
   task automatic test_uart_wait(input string name, input logic we, input int ready_at,
                                 input int want_cycles, input logic want_err,
                                 input logic [31:0] want_rd);
      int n = 0;
      bit done = 0;
      drive_req(we, 32'h8000_000C, 32'h55, 4'hF);
      for (int i = 0; i < 300 && !done; i++) begin
         step();
         bus.uart_ready = (ready_at != 0) && (n + 1 == ready_at);
         bus.uart_rdata = 32'h77;
         #1;
         if (bus.uart_sel === 1'b1) n++;
         else done = 1;
      end
      bus.uart_ready = 1'b0;
      bus.req_valid  = 1'b0;
      #1;
      total++;
      if (!done || n !== want_cycles)
         $display("FAIL %s_cycles sel_cycles=%0d ended=%0b want %0d", name, n, done, want_cycles);
      else passed++;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== want_err || bus.rsp_rdata !== want_rd)
         $display("FAIL %s_rsp rsp=%b err=%b rd=%h want 1 %b %h",
                  name, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, want_err, want_rd);
      else passed++;
      step();
      #1;
      total++;
      if (bus.rsp_valid !== 1'b0 || bus.req_stall !== 1'b0 || bus.uart_sel !== 1'b0)
         $display("FAIL %s_idle rsp=%b stall=%b usel=%b want 000",
                  name, bus.rsp_valid, bus.req_stall, bus.uart_sel);
      else passed++;
   endtask

   task automatic test_unmapped();
      drive_req(1'b0, 32'h5000_0000, 32'h0, 4'hF);
      bus.dmem_rdata = 32'hAAAA_AAAA;
      bus.uart_rdata = 32'hBBBB_BBBB;
      #1;
      total++;
      if (bus.req_stall !== 1'b1) $display("FAIL unm_t0 stall=%b want 1", bus.req_stall);
      else passed++;
      step();
      bus.req_valid = 1'b0;
      #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0 ||
          bus.dmem_sel !== 1'b0 || bus.uart_sel !== 1'b0)
         $display("FAIL unm_t1 rsp=%b err=%b rd=%h dsel=%b usel=%b want 1 1 0 0 0",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.dmem_sel, bus.uart_sel);
      else passed++;
      step();
   endtask

   task automatic test_reset_mid_uart();
      drive_req(1'b0, 32'h8000_0000, 32'h0, 4'hF);
      step();
      step();
      rst = 1'b1;
      bus.req_valid = 1'b0;
      #1;
      total++;
      if (bus.uart_sel !== 1'b0) $display("FAIL rmid_drop usel=%b want 0", bus.uart_sel);
      else passed++;
      step();
      rst = 1'b0;
      #1;
      total++;
      if (bus.uart_sel !== 1'b0 || bus.req_stall !== 1'b0 || bus.rsp_valid !== 1'b0)
         $display("FAIL rmid_after usel=%b stall=%b rsp=%b want 000",
                  bus.uart_sel, bus.req_stall, bus.rsp_valid);
      else passed++;
      drive_req(1'b0, 32'h2000_0020, 32'h0, 4'hF);
      step();
      #1;
      total++;
      if (bus.dmem_sel !== 1'b1 || bus.dmem_addr !== 32'h2000_0020)
         $display("FAIL rmid_dsel sel=%b a=%h want 1 20000020", bus.dmem_sel, bus.dmem_addr);
      else passed++;
      step();
      bus.req_valid  = 1'b0;
      bus.dmem_rdata = 32'hCAFE_F00D;
      #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'hCAFE_F00D)
         $display("FAIL rmid_rsp rsp=%b err=%b rd=%h want 1 0 cafef00d",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
      else passed++;
      step();
   endtask

   task automatic test_back_to_back();
      drive_req(1'b0, 32'h2000_0040, 32'h0, 4'hF);
      step();
      step();
      drive_req(1'b0, 32'h0000_0000, 32'h0, 4'hF);
      bus.dmem_rdata = 32'h0000_0042;
      #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.req_stall !== 1'b0 || bus.rsp_rdata !== 32'h42)
         $display("FAIL b2b_resp rsp=%b stall=%b rd=%h want 1 0 42",
                  bus.rsp_valid, bus.req_stall, bus.rsp_rdata);
      else passed++;
      step();
      #1;
      total++;
      if (bus.rsp_valid !== 1'b0 || bus.req_stall !== 1'b1)
         $display("FAIL b2b_gap rsp=%b stall=%b want 0 1", bus.rsp_valid, bus.req_stall);
      else passed++;
      step();
      bus.req_valid = 1'b0;
      #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1)
         $display("FAIL b2b_second rsp=%b err=%b want 1 1", bus.rsp_valid, bus.rsp_err);
      else passed++;
      step();
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_mask   = '0;
      bus.dmem_rdata = '0;
      bus.uart_ready = 1'b0;
      bus.uart_rdata = '0;
      test_reset();
      test_dmem_store();
      test_dmem_load();
      test_uart_load();
      test_uart_wait("uto", 1'b1, 0, 255, 1'b1, 32'h0);
      test_uart_wait("urace", 1'b0, 255, 255, 1'b0, 32'h77);
      test_unmapped();
      test_reset_mid_uart();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog sim time exceeded, passed=%0d total=%0d", passed, total);
      $fatal(1);
   end

endmodule

// File: doc/dbus_ctrl.md
Name: dbus_ctrl

Overview:
- Data-bus controller between the core's load/store stage and the data-side slaves (DMEM, UART).
- Accepts one load/store request at a time and decodes the target region from addr[31:28].
- Sequences the slave access: fixed 1-cycle synchronous-read DMEM, or valid/ready UART with a timeout.
- Stalls the pipeline until the access completes, then returns a one-cycle response with read data and an error flag.

Parameters:
- DATA_WIDTH, 32, data/address bus width.
- DMEM_REGION, 4'h2, addr[31:28] value that selects DMEM.
- UART_REGION, 4'h8, addr[31:28] value that selects UART.
- TIMEOUT, 255, UART wait cycles before bus error (1..65535).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  load/store request from core; held stable while req_stall=1.
- req_we  in  1  1=store, 0=load.
- req_addr  in  DATA_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data.
- req_mask  in  4  byte enables.
- req_stall  out  1  core must hold its pipeline.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors.
- rsp_err  out  1  unmapped region or UART timeout; qualified by rsp_valid.
- dmem_sel  out  1  DMEM access strobe.
- dmem_we  out  1  DMEM write enable.
- dmem_addr  out  DATA_WIDTH  DMEM address.
- dmem_wdata  out  DATA_WIDTH  DMEM write data.
- dmem_mask  out  4  DMEM byte enables.
- dmem_rdata  in  DATA_WIDTH  DMEM read data, valid the cycle after dmem_sel.
- uart_sel  out  1  UART request valid.
- uart_we  out  1  UART write.
- uart_addr  out  4  UART register offset = addr[3:0].
- uart_wdata  out  DATA_WIDTH  UART write data.
- uart_ready  in  1  UART accepts / completes the request this cycle.
- uart_rdata  in  DATA_WIDTH  UART read data, valid with uart_ready.

Behaviour:
- States: IDLE, DMEM_ACC, UART_ACC, RESP.
- Reset (any state, including mid-access):
  - state=IDLE, timeout counter=0, latched request cleared.
  - All outputs 0; uart_sel drops immediately.
  - Reset wins over any simultaneous event.
- IDLE:
  - req_valid is sampled only in IDLE.
  - req_stall = req_valid, combinational in IDLE.
  - On req_valid, latch we/addr/wdata/mask and decode addr[31:28]:
    - DMEM_REGION -> DMEM_ACC.
    - UART_REGION -> UART_ACC.
    - Otherwise -> RESP with err=1.
- DMEM_ACC (exactly one cycle):
  - dmem_sel=1; dmem_we/addr/wdata/mask driven from the latched request.
  - Next state RESP.
- UART_ACC:
  - uart_sel=1 with latched fields, held stable until uart_ready.
  - Timeout counter increments each cycle uart_ready=0.
  - uart_ready=1: capture uart_rdata (loads only), go to RESP with err=0.
  - Counter reaches TIMEOUT with no ready: drop uart_sel, go to RESP with err=1.
  - uart_ready in the same cycle as the timeout: ready wins, err=0.
- RESP (exactly one cycle):
  - rsp_valid=1, req_stall=0, then IDLE.
  - rsp_rdata by source:
    - DMEM load: dmem_rdata, passed through.
    - UART load: captured value.
    - Stores and errors: 0.
  - Counter cleared.
- req_stall is 1 in IDLE-with-request, DMEM_ACC and UART_ACC; 0 in RESP and idle-without-request.
- No new request is accepted in RESP; the earliest next accept is the cycle after RESP, so back-to-back requests are spaced by one idle cycle.
- Latency from accept cycle T0 to rsp_valid:
  - DMEM: T0+2.
  - UART: T0+1+N, N = cycles until ready (N≥1).
  - Unmapped: T0+1.
- dmem_sel and uart_sel are never both 1. Neither is asserted outside its ACC state.
- req_mask is passed unchanged; no alignment checking.

Test Plan:
- DMEM store addr=0x2000_0010, wdata=0xDEADBEEF, mask=4'hF at T0 -> dmem_sel=dmem_we=1 at T1 with those values; rsp_valid=1, rsp_err=0, rsp_rdata=0 at T2; req_stall=1 at T0–T1, 0 at T2.
- DMEM load addr=0x2000_0010, dmem_rdata=0xDEADBEEF at T2 -> rsp_rdata=0xDEADBEEF, rsp_valid at T2; no uart_sel at any time.
- UART load addr=0x8000_0004, uart_ready after 3 wait cycles, uart_rdata=0x41 -> uart_sel held 4 cycles with uart_addr=4; rsp_valid next cycle with rsp_rdata=0x41, err=0.
- UART store with uart_ready never asserted, TIMEOUT=255 -> uart_sel drops after 255 wait cycles; rsp_valid=1, rsp_err=1 the following cycle; FSM returns to IDLE.
- Unmapped addr=0x5000_0000 load -> no slave strobe; rsp_valid=1, rsp_err=1, rsp_rdata=0 at T0+1.
- rst=1 asserted on the 2nd cycle of a UART wait -> next cycle uart_sel=0, req_stall=0, rsp_valid=0; a new DMEM request after reset completes normally at T0+2.
